// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector: gathers D_WIDTH complex samples per frame and presents
// each completed frame as parallel real/imag arrays for the FFT bit-reversal router.
module fft_frame_collector #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] outputRe [D_WIDTH],
    output logic [15:0] outputIm [D_WIDTH],
    output logic        frame_err
);

    localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    logic [15:0]            bank_re [2][D_WIDTH];
    logic [15:0]            bank_im [2][D_WIDTH];
    logic [LOG_2_WIDTH-1:0] wr_ptr;
    logic                   fill_bank;
    logic                   rd_bank;
    logic [1:0]             bank_full;

    logic accept;
    logic take;
    logic at_end;
    logic complete;

    // Handshake: a sample moves when in_valid && in_ready; a frame moves when
    // frame_valid && frame_ready. Both ready/valid outputs depend only on registers.
    assign in_ready    = !bank_full[fill_bank];
    assign frame_valid = bank_full[rd_bank];
    assign accept      = in_valid && in_ready;
    assign take        = frame_valid && frame_ready;
    assign at_end      = (wr_ptr == LAST_IDX);
    assign complete    = accept && at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill_bank <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                if (at_end) begin
                    wr_ptr    <= '0;
                    fill_bank <= !fill_bank;
                    if (!in_last) begin
                        frame_err <= 1'b1;
                    end
                end else if (in_last) begin
                    // Short frame: drop it and refill the same bank from index 0.
                    wr_ptr    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + LOG_2_WIDTH'(1);
                end
            end
            if (take) begin
                rd_bank <= !rd_bank;
            end
            // Completion and release never hit the same bank: the fill bank is
            // empty and the read bank is full whenever either fires.
            for (int b = 0; b < 2; b++) begin
                if (complete && (fill_bank == 1'(b))) begin
                    bank_full[b] <= 1'b1;
                end else if (take && (rd_bank == 1'(b))) begin
                    bank_full[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < D_WIDTH; i++) begin
                    bank_re[b][i] <= '0;
                    bank_im[b][i] <= '0;
                end
            end
        end else if (accept) begin
            bank_re[fill_bank][wr_ptr] <= in_re;
            bank_im[fill_bank][wr_ptr] <= in_im;
        end
    end

    always_comb begin
        for (int i = 0; i < D_WIDTH; i++) begin
            outputRe[i] = bank_re[rd_bank][i];
            outputIm[i] = bank_im[rd_bank][i];
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Bench for fft_frame_collector: directed and random streams checked every cycle
// against a frame-level model built from queues of expected samples.
module tb_fft_frame_collector;

    localparam int D = 64;
    localparam int LW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] outputRe [D];
    logic [15:0] outputIm [D];
    logic        frame_err;

    fft_frame_collector #(.D_WIDTH(D), .LOG_2_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_re      (in_re),
        .in_im      (in_im),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .outputRe   (outputRe),
        .outputIm   (outputIm),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];   // completed frames awaiting release, {re,im} per sample
    logic [31:0] cur_q[$];   // partial frame being collected
    bit          model_err = 1'b0;
    logic [15:0] snap_re [D];
    logic [15:0] snap_im [D];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic check_zero_outputs(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < D; i++) begin
            if ({outputRe[i], outputIm[i]} !== 32'h0 && bad == 0) bad = i + 1;
        end
        if (bad != 0) check(tag, {outputRe[bad-1], outputIm[bad-1]}, 32'h0);
        else check(tag, {outputRe[0], outputIm[0]}, 32'h0);
    endtask

    task automatic check_state();
        int held;
        int bad;
        held = exp_q.size() / D;
        check_bit("in_ready", in_ready, held < 2);
        check_bit("frame_valid", frame_valid, held > 0);
        check_bit("frame_err", frame_err, model_err);
        if (held > 0) begin
            bad = 0;
            for (int i = 0; i < D; i++) begin
                if ({outputRe[i], outputIm[i]} !== exp_q[i] && bad == 0) bad = i + 1;
            end
            if (bad != 0) check("frame_data", {outputRe[bad-1], outputIm[bad-1]}, exp_q[bad-1]);
            else check("frame_data", {outputRe[0], outputIm[0]}, exp_q[0]);
        end
    endtask

    // One clock: drive inputs, advance, update the model, compare.
    task automatic cycle(input bit v, input bit last, input logic [15:0] re,
                         input logic [15:0] im, input bit fr, output bit acc);
        int held;
        bit take;
        bit hold;
        int bad;
        held = exp_q.size() / D;
        in_valid    = v;
        in_last     = last;
        in_re       = re;
        in_im       = im;
        frame_ready = fr;
        acc  = v && (held < 2);
        take = fr && (held > 0);
        hold = (held > 0) && !fr;
        @(posedge clk);
        #1;
        if (take) repeat (D) void'(exp_q.pop_front());
        if (acc) begin
            cur_q.push_back({re, im});
            if (cur_q.size() == D) begin
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                if (!last) model_err = 1'b1;
                cur_q.delete();
            end else if (last) begin
                model_err = 1'b1;
                cur_q.delete();
            end
        end
        check_state();
        if (hold) begin
            bad = 0;
            for (int i = 0; i < D; i++) begin
                if ({outputRe[i], outputIm[i]} !== {snap_re[i], snap_im[i]} && bad == 0) bad = i + 1;
            end
            if (bad != 0) check("hold_stable", {outputRe[bad-1], outputIm[bad-1]}, {snap_re[bad-1], snap_im[bad-1]});
            else check("hold_stable", {outputRe[0], outputIm[0]}, {snap_re[0], snap_im[0]});
        end
        for (int i = 0; i < D; i++) begin
            snap_re[i] = outputRe[i];
            snap_im[i] = outputIm[i];
        end
    endtask

    task automatic send_sample(input logic [15:0] re, input logic [15:0] im, input bit last,
                               input int gap_pct, input int fr_pct);
        bit acc;
        bit v;
        bit fr;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 500) begin
            v  = ($urandom_range(99) >= gap_pct);
            fr = ($urandom_range(99) < fr_pct);
            cycle(v, last, re, im, fr, acc);
            n++;
        end
        check_bit("accept_timeout", acc, 1'b1);
    endtask

    task automatic send_frame(input int base, input int n, input int last_at,
                              input int gap_pct, input int fr_pct);
        for (int k = 0; k < n; k++) begin
            send_sample(16'(base + k), 16'(-(base + k)), k == last_at, gap_pct, fr_pct);
        end
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (n < 4 || (exp_q.size() > 0 && n < 20)) begin
            cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_re = '0;
        in_im = '0;
        frame_ready = 1'b0;
        exp_q.delete();
        cur_q.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        check_zero_outputs("reset_outputs");
        for (int i = 0; i < D; i++) begin
            snap_re[i] = outputRe[i];
            snap_im[i] = outputIm[i];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;

        // Single natural-order frame, consumer always ready.
        do_reset();
        send_frame(0, D, D - 1, 0, 100);
        check("t1_re63", {16'h0, outputRe[63]}, 32'd63);
        check("t1_im63", {16'h0, outputIm[63]}, {16'h0, 16'(-63)});
        drain();

        // Three frames with consumer stalled: frame 2 waits at index 0.
        do_reset();
        send_frame(0, D, D - 1, 0, 0);
        send_frame(64, D, D - 1, 0, 0);
        check_bit("t2_in_ready_low", in_ready, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 16'd128, 16'(-128), 1'b0, acc);
        cycle(1'b1, 1'b0, 16'd128, 16'(-128), 1'b1, acc);
        check_bit("t2_ready_after_release", in_ready, 1'b1);
        check("t2_frame1_shown", {16'h0, outputRe[0]}, 32'd64);
        send_frame(128, D, D - 1, 0, 100);
        drain();

        // Sample 63 without in_last: frame completes, error flagged.
        do_reset();
        send_frame(300, D, -1, 0, 100);
        check_bit("t4_err", frame_err, 1'b1);
        drain();

        // Early in_last at index 10, then a clean frame of 100+k.
        do_reset();
        send_frame(500, 11, 10, 0, 0);
        check_bit("t3_err", frame_err, 1'b1);
        send_frame(100, D, D - 1, 0, 0);
        check("t3_first", {16'h0, outputRe[0]}, 32'd100);
        check("t3_last", {16'h0, outputRe[63]}, 32'd163);
        drain();
        check_bit("t3_err_sticky", frame_err, 1'b1);

        // Random gaps and random consumer over 20 frames of random data.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < D; k++) begin
                send_sample(16'($urandom), 16'($urandom), k == D - 1, 30, 40);
            end
        end
        drain();

        // Reset mid-frame (index 30) while a frame is held.
        do_reset();
        send_frame(1000, D, D - 1, 0, 0);
        send_frame(2000, 30, -1, 0, 0);
        rst = 1'b1;
        #1;
        check_bit("t6_rst_valid", frame_valid, 1'b0);
        check_bit("t6_rst_ready", in_ready, 1'b1);
        check_bit("t6_rst_err", frame_err, 1'b0);
        check_zero_outputs("t6_rst_outputs");
        exp_q.delete();
        cur_q.delete();
        model_err = 1'b0;
        in_valid = 1'b0;
        frame_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            snap_re[i] = outputRe[i];
            snap_im[i] = outputIm[i];
        end
        send_frame(3000, D, D - 1, 0, 0);
        check("t6_index0", {16'h0, outputRe[0]}, 32'd3000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
